fft_sym_sched: RTL and testbench
================================

Name: fft_sym_sched

Overview:
- Symbol scheduler in front of the receiver FFT.
- Accepts the continuous time-domain sample stream on a Wishbone-style slave port and discards the cyclic prefix of every OFDM symbol.
- Forwards exactly NFFT useful samples per symbol to the FFT on a Wishbone-style master port, tagging the last sample of each symbol.
- Counts symbols per frame and, at frame end, releases the bus and reports completion or abort status to the receiver control.

Parameters:
- NFFT, 2048: FFT size in samples; power of two, minimum 32.
- SYM_PER_FRM, 26: OFDM symbols per frame.
- DW, 32: sample width; Im in [DW-1:DW/2], Re in [DW/2-1:0].

Ports:
- CLK_I, in, 1: clock.
- RST_I, in, 1: reset, asynchronous, active-low.
- CP_SEL, in, 2: cyclic prefix select. CP_LEN = NFFT >> (2+CP_SEL), giving 1/4, 1/8, 1/16 or 1/32 of NFFT.
- DAT_I, in, DW: input sample.
- WE_I, in, 1: slave write enable.
- STB_I, in, 1: slave strobe.
- CYC_I, in, 1: slave cycle; high for the whole frame.
- ACK_O, out, 1: slave accept.
- DAT_O, out, DW: sample to FFT.
- CYC_O, out, 1: master cycle.
- STB_O, out, 1: master strobe.
- WE_O, out, 1: master write enable; equals STB_O.
- ACK_I, in, 1: FFT accept.
- LAST_O, out, 1: qualifies STB_O; marks sample NFFT-1 of a symbol.
- SYM_IDX_O, out, 8: index of the symbol currently being forwarded.
- FRM_DONE_O, out, 1: one-cycle pulse after the last sample of symbol SYM_PER_FRM-1 is accepted.
- ABORT_O, out, 1: one-cycle pulse when CYC_I falls mid-frame.

Behaviour:
- Reset (RST_I low): all outputs and state 0, DAT_O = 0, FSM = IDLE. Takes effect immediately, including mid-symbol; any pending output is dropped.
- Input beat: wr = CYC_I & STB_I & WE_I & ACK_O.
- Output register (rdy):
  - rdy = ~STB_O | ACK_I.
  - When rdy: STB_O <= beat valid in BODY; DAT_O and LAST_O load with it.
  - Latency from input beat to STB_O is 1 cycle.
- FSM states: IDLE, CP, BODY, DRAIN.
- IDLE:
  - ACK_O = 0. cp_len is latched from CP_SEL each cycle.
  - CYC_I & STB_I & WE_I -> CP, cnt = 0, sym = 0.
- CP:
  - ACK_O = 1. Each wr discards the sample and increments cnt.
  - Sample with cnt == cp_len-1 accepted -> BODY, cnt = 0.
- BODY:
  - ACK_O = rdy. Each wr forwards the sample and increments cnt.
  - Sample with cnt == NFFT-1 carries LAST_O = 1.
  - On that beat: if sym == SYM_PER_FRM-1 -> DRAIN; else sym++, cp_len relatched from CP_SEL, -> CP.
- DRAIN:
  - ACK_O = 0. Waits until ~STB_O | ACK_I.
  - Then FRM_DONE_O = 1 for one cycle -> IDLE.
- CYC_I low while in CP or BODY: ABORT_O pulses, counters clear, -> DRAIN. Any pending output still completes; FRM_DONE_O is not pulsed on abort.
- CP_SEL only takes effect at a symbol boundary; changes mid-symbol are ignored.
- SYM_IDX_O = sym, registered. Increments on the LAST beat. Holds the value SYM_PER_FRM-1 through DRAIN, then returns to 0 in IDLE.
- CYC_O:
  - Set on the first STB_O of a frame.
  - Cleared in the cycle DRAIN exits.
  - Never low while STB_O = 1.
- Back-pressure: ACK_I = 0 with STB_O = 1 holds DAT_O, LAST_O and STB_O stable and forces ACK_O = 0 in BODY. No sample is lost or duplicated.
- Counter widths: cnt is log2(NFFT) bits; sym is 8 bits. No wrap occurs inside a legal frame.

Test Plan:
- Basic frame: NFFT=32, SYM_PER_FRM=2, CP_SEL=1 (CP 4); 72 samples valued 0..71 with ACK_I=1.
  - Output 32 beats DAT 4..35 (LAST on 35), then 40..71 (LAST on 71).
  - FRM_DONE_O pulses one cycle after the final accept; CYC_O then 0.
- CP select sweep: CP_SEL=0, 2, 3 over one symbol each.
  - Discard counts are exactly 8, 2 and 1.
  - First forwarded sample is input index 8, 2 and 1 respectively.
- Back-pressure: hold ACK_I=0 for 5 cycles mid-BODY.
  - DAT_O is stable and ACK_O = 0 throughout.
  - After release, the sequence continues with no gap and no duplicate; total body beats = 32.
- CP_SEL change: change CP_SEL from 1 to 3 during symbol 0 body.
  - Symbol 0 is unaffected.
  - Symbol 1 discards 1 sample.
- Abort: drop CYC_I at body sample 10 of symbol 0.
  - ABORT_O pulses; the pending beat drains; no FRM_DONE_O; CYC_O -> 0; FSM returns to IDLE.
  - The next frame behaves like the basic frame.
- Async reset: pull RST_I low mid-CP while ACK_I=0 and STB_O=1.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After RST_I rises, the next frame is correct.

Source files
------------

// File: rtl/fft_sym_sched.sv
// fft_sym_sched
// Symbol scheduler sitting in front of the receiver FFT. Takes the
// continuous time-domain sample stream on a Wishbone-style slave port, drops
// the cyclic prefix of every OFDM symbol and forwards exactly NFFT useful
// samples per symbol on a Wishbone-style master port, tagging the last
// sample of each symbol. At frame end the master bus is released and a
// done (or abort) pulse goes to the receiver control.
//
// Ports
//   CLK_I, RST_I          clock, asynchronous active-low reset
//   CP_SEL                cyclic prefix select, CP = NFFT >> (2+CP_SEL)
//   DAT_I/WE_I/STB_I/CYC_I/ACK_O
//                         slave port (sample stream in)
//   DAT_O/CYC_O/STB_O/WE_O/ACK_I/LAST_O
//                         master port (samples to the FFT)
//   SYM_IDX_O             index of the symbol being forwarded
//   FRM_DONE_O            one-cycle pulse when the frame's final sample is taken
//   ABORT_O               one-cycle pulse when CYC_I drops mid-frame
module fft_sym_sched #(
    parameter int NFFT        = 2048,
    parameter int SYM_PER_FRM = 26,
    parameter int DW          = 32
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [1:0]    CP_SEL,
    input  logic [DW-1:0] DAT_I,
    input  logic          WE_I,
    input  logic          STB_I,
    input  logic          CYC_I,
    output logic          ACK_O,
    output logic [DW-1:0] DAT_O,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    input  logic          ACK_I,
    output logic          LAST_O,
    output logic [7:0]    SYM_IDX_O,
    output logic          FRM_DONE_O,
    output logic          ABORT_O
);

    localparam int CNT_W = $clog2(NFFT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CP    = 2'd1;
    localparam logic [1:0] S_BODY  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BODY_END = CNT_W'(NFFT - 1);
    localparam logic [7:0]       SYM_LAST = 8'(SYM_PER_FRM - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cp_len;
    logic [CNT_W-1:0] cp_sel_len;
    logic [7:0]       sym;
    logic             aborted;   // frame ended by CYC_I drop; suppresses FRM_DONE_O

    logic rdy;
    logic wr;
    logic fwd;
    logic body_end;

    // Prefix length decoded from the live select; only sampled in IDLE and
    // on the LAST beat, so mid-symbol changes never disturb the count.
    always_comb begin
        case (CP_SEL)
            2'd0:    cp_sel_len = CNT_W'(NFFT / 4);
            2'd1:    cp_sel_len = CNT_W'(NFFT / 8);
            2'd2:    cp_sel_len = CNT_W'(NFFT / 16);
            default: cp_sel_len = CNT_W'(NFFT / 32);
        endcase
    end

    // Output register can take a new sample when empty or being emptied.
    assign rdy      = ~STB_O | ACK_I;
    assign body_end = (cnt == BODY_END);

    // NOTE: ACK_O gets a default before the case so no path leaves it
    // unassigned; otherwise this combinational block would infer a latch.
    always_comb begin
        ACK_O = 1'b0;
        case (state)
            S_CP:    ACK_O = 1'b1;   // prefix samples are dropped, never stall
            S_BODY:  ACK_O = rdy;    // back-pressure from the FFT passes through
            default: ACK_O = 1'b0;
        endcase
    end

    assign wr        = CYC_I & STB_I & WE_I & ACK_O;
    assign fwd       = wr & (state == S_BODY);
    assign WE_O      = STB_O;
    assign SYM_IDX_O = sym;

    // Control FSM: prefix/body counting, symbol counting, frame end.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; RST_I clears it asynchronously, no clock needed.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cp_len     <= '0;
            sym        <= '0;
            aborted    <= 1'b0;
            FRM_DONE_O <= 1'b0;
            ABORT_O    <= 1'b0;
        end else begin
            FRM_DONE_O <= 1'b0;
            ABORT_O    <= 1'b0;
            case (state)
                S_IDLE: begin
                    cp_len  <= cp_sel_len;
                    cnt     <= '0;
                    sym     <= '0;
                    aborted <= 1'b0;
                    if (CYC_I && STB_I && WE_I) begin
                        state <= S_CP;
                    end
                end
                S_CP, S_BODY: begin
                    if (!CYC_I) begin
                        // Master dropped the frame: clear counters and let any
                        // sample already in the output register finish.
                        ABORT_O <= 1'b1;
                        aborted <= 1'b1;
                        cnt     <= '0;
                        sym     <= '0;
                        state   <= S_DRAIN;
                    end else if (wr) begin
                        if (state == S_CP) begin
                            if (cnt == cp_len - CNT_ONE) begin
                                cnt   <= '0;
                                state <= S_BODY;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else if (body_end) begin
                            cnt <= '0;
                            if (sym == SYM_LAST) begin
                                state <= S_DRAIN;
                            end else begin
                                sym    <= sym + 8'd1;
                                cp_len <= cp_sel_len;
                                state  <= S_CP;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rdy) begin
                        FRM_DONE_O <= ~aborted;
                        sym        <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Master-side output register. Held while the FFT stalls; reloaded with
    // the forwarded body sample (or emptied) whenever it is free.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            STB_O  <= 1'b0;
            LAST_O <= 1'b0;
            DAT_O  <= '0;
            CYC_O  <= 1'b0;
        end else begin
            if (rdy) begin
                STB_O  <= fwd;
                LAST_O <= fwd & body_end;
                if (fwd) begin
                    DAT_O <= DAT_I;
                end
            end
            // Bus is released only once DRAIN has seen the output register
            // free, so CYC_O never falls under a live STB_O.
            if ((state == S_DRAIN) && rdy) begin
                CYC_O <= 1'b0;
            end else if (fwd) begin
                CYC_O <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_sym_sched.sv
// tb_fft_sym_sched
// Directed bench for fft_sym_sched with NFFT=32, SYM_PER_FRM=2. Body samples
// are pushed to an expected queue as they are driven; a monitor pops and
// compares each beat the FFT side accepts.
module tb_fft_sym_sched;

    localparam int NFFT = 32;
    localparam int SPF  = 2;
    localparam int DW   = 32;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } exp_t;

    logic          CLK_I;
    logic          RST_I;
    logic [1:0]    CP_SEL;
    logic [DW-1:0] DAT_I;
    logic          WE_I;
    logic          STB_I;
    logic          CYC_I;
    logic          ACK_O;
    logic [DW-1:0] DAT_O;
    logic          CYC_O;
    logic          STB_O;
    logic          WE_O;
    logic          ACK_I;
    logic          LAST_O;
    logic [7:0]    SYM_IDX_O;
    logic          FRM_DONE_O;
    logic          ABORT_O;

    fft_sym_sched #(.NFFT(NFFT), .SYM_PER_FRM(SPF), .DW(DW)) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .CP_SEL     (CP_SEL),
        .DAT_I      (DAT_I),
        .WE_I       (WE_I),
        .STB_I      (STB_I),
        .CYC_I      (CYC_I),
        .ACK_O      (ACK_O),
        .DAT_O      (DAT_O),
        .CYC_O      (CYC_O),
        .STB_O      (STB_O),
        .WE_O       (WE_O),
        .ACK_I      (ACK_I),
        .LAST_O     (LAST_O),
        .SYM_IDX_O  (SYM_IDX_O),
        .FRM_DONE_O (FRM_DONE_O),
        .ABORT_O    (ABORT_O)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_pop_cyc = 0;
    int   next_val = 0;
    int   sym_cp = 0;
    exp_t exp_q[$];

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every beat the FFT accepts must match the queue head.
    always @(negedge CLK_I) begin
        if (RST_I && STB_O) begin
            check("cyc_under_stb", 32'(CYC_O), 32'd1);
            check("we_eq_stb", 32'(WE_O), 32'd1);
            if (ACK_I) begin
                check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("dat_o", DAT_O, e.dat);
                    check("last_o", 32'(LAST_O), 32'(e.last));
                end
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic send_sample(input logic body, input logic last);
        logic ok;
        DAT_I = DW'(next_val);
        STB_I = 1'b1;
        WE_I  = 1'b1;
        if (body) exp_q.push_back(exp_t'({DW'(next_val), last}));
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK_I);
            if (ACK_O) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_in_time", 32'(ok), 32'd1);
        @(posedge CLK_I);
        #1;
        next_val++;
    endtask

    // FFT stalls while the next body sample is offered: output must hold.
    task automatic stall_output(input int n);
        logic [DW-1:0] held;
        held  = DW'(next_val - 1);
        ACK_I = 1'b0;
        DAT_I = DW'(next_val);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK_I);
            check("bp_ack_o", 32'(ACK_O), 32'd0);
            check("bp_stb_o", 32'(STB_O), 32'd1);
            check("bp_dat_o", DAT_O, held);
        end
        @(posedge CLK_I);
        #1;
        ACK_I = 1'b1;
    endtask

    task automatic start_frame(input logic [1:0] sel);
        CP_SEL   = sel;
        CYC_I    = 1'b1;
        next_val = 0;
        sym_cp   = NFFT >> (2 + int'(sel));
    endtask

    task automatic send_symbol(input int s, input int stall_at, input int chg_at,
                               input logic [1:0] chg_sel);
        for (int i = 0; i < sym_cp; i++) send_sample(1'b0, 1'b0);
        for (int i = 0; i < NFFT; i++) begin
            if (i == chg_at) CP_SEL = chg_sel;
            if (i == stall_at) stall_output(5);
            if (i == 5) check("sym_idx", 32'(SYM_IDX_O), 32'(s));
            send_sample(1'b1, i == NFFT - 1);
        end
        sym_cp = NFFT >> (2 + int'(CP_SEL));
    endtask

    task automatic finish_frame();
        logic found;
        STB_I = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK_I);
            if (FRM_DONE_O) begin
                found = 1'b1;
                break;
            end
        end
        check("frm_done_seen", 32'(found), 32'd1);
        check("frm_done_latency", 32'(cyc - last_pop_cyc), 32'd1);
        @(negedge CLK_I);
        check("frm_done_one_cycle", 32'(FRM_DONE_O), 32'd0);
        check("cyc_o_released", 32'(CYC_O), 32'd0);
        check("sym_idx_idle", 32'(SYM_IDX_O), 32'd0);
        check("stb_o_idle", 32'(STB_O), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge CLK_I);
        #1;
        CYC_I = 1'b0;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic basic_frame();
        start_frame(2'd1);
        send_symbol(0, -1, -1, 2'd1);
        send_symbol(1, -1, -1, 2'd1);
        finish_frame();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stb"},   32'(STB_O), 32'd0);
        check({tag, "_cyc"},   32'(CYC_O), 32'd0);
        check({tag, "_ack"},   32'(ACK_O), 32'd0);
        check({tag, "_dat"},   DAT_O, 32'd0);
        check({tag, "_last"},  32'(LAST_O), 32'd0);
        check({tag, "_sym"},   32'(SYM_IDX_O), 32'd0);
        check({tag, "_done"},  32'(FRM_DONE_O), 32'd0);
        check({tag, "_abort"}, 32'(ABORT_O), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int frm_seen;
        RST_I  = 1'b0;
        CP_SEL = 2'd0;
        DAT_I  = '0;
        WE_I   = 1'b0;
        STB_I  = 1'b0;
        CYC_I  = 1'b0;
        ACK_I  = 1'b1;

        // Reset state
        repeat (2) @(negedge CLK_I);
        check_all_zero("reset");
        #1 RST_I = 1'b1;
        @(posedge CLK_I);
        #1;

        // Basic frame: CP 4, bodies 4..35 and 40..71
        basic_frame();

        // CP sweep: CP_SEL 0 then 2 (changed during symbol 0 body), then 3
        start_frame(2'd0);
        send_symbol(0, -1, 0, 2'd2);
        send_symbol(1, -1, -1, 2'd2);
        finish_frame();
        start_frame(2'd3);
        send_symbol(0, -1, -1, 2'd3);
        send_symbol(1, -1, -1, 2'd3);
        finish_frame();

        // Back-pressure for 5 cycles in the middle of symbol 0 body
        start_frame(2'd1);
        send_symbol(0, 12, -1, 2'd1);
        send_symbol(1, -1, -1, 2'd1);
        finish_frame();

        // CP_SEL 1 -> 3 during symbol 0 body; symbol 1 then drops 1 sample
        start_frame(2'd1);
        send_symbol(0, -1, 10, 2'd3);
        send_symbol(1, -1, -1, 2'd3);
        finish_frame();

        // Abort at body sample 10 of symbol 0, with the pending beat stalled
        start_frame(2'd1);
        for (int i = 0; i < sym_cp; i++) send_sample(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_sample(1'b1, 1'b0);
        CYC_I = 1'b0;
        STB_I = 1'b0;
        ACK_I = 1'b0;
        @(negedge CLK_I);
        check("abort_not_yet", 32'(ABORT_O), 32'd0);
        check("abort_pending_ack", 32'(ACK_O), 32'd0);
        @(negedge CLK_I);
        check("abort_pulse", 32'(ABORT_O), 32'd1);
        check("abort_pending_stb", 32'(STB_O), 32'd1);
        check("abort_pending_dat", DAT_O, DW'(next_val - 1));
        @(negedge CLK_I);
        check("abort_one_cycle", 32'(ABORT_O), 32'd0);
        check("abort_drain_stb", 32'(STB_O), 32'd1);
        @(posedge CLK_I);
        #1;
        ACK_I = 1'b1;
        frm_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK_I);
            if (FRM_DONE_O) frm_seen++;
        end
        check("abort_no_frm_done", 32'(frm_seen), 32'd0);
        check("abort_cyc_o", 32'(CYC_O), 32'd0);
        check("abort_stb_o", 32'(STB_O), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        check("abort_idle_ack", 32'(ACK_O), 32'd0);
        @(posedge CLK_I);
        #1;
        basic_frame();

        // Asynchronous reset mid-CP of symbol 1 with a stalled output beat
        start_frame(2'd1);
        send_symbol(0, -1, -1, 2'd1);
        ACK_I = 1'b0;
        send_sample(1'b0, 1'b0);
        send_sample(1'b0, 1'b0);
        check("pre_reset_stb", 32'(STB_O), 32'd1);
        check("pre_reset_last", 32'(LAST_O), 32'd1);
        #2;
        RST_I = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        STB_I = 1'b0;
        CYC_I = 1'b0;
        ACK_I = 1'b1;
        @(negedge CLK_I);
        #1 RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        basic_frame();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
